// File: rtl/uart_bus_responder.sv
// Memory-mapped 8N1 UART responder with TX/RX FIFOs on the rd_en/wr_en/ack bus.
// Optional IRQ_EN register and irq_o output when UART_IRQ_EN is defined.
module uart_bus_responder #(
  parameter int CLOCK_FREQ  = 25000000,
  parameter int BIT_RATE    = 9600,
  parameter int BUFFER_SIZE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en_i,
  input  logic        wr_en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  input  logic        rx,
  output logic        tx
`ifdef UART_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int BAUD_DIV = CLOCK_FREQ / BIT_RATE;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam int AW       = $clog2(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic             r_ack;
  logic [31:0]      r_rdata;
  logic [7:0]       r_tx_mem [BUFFER_SIZE];
  logic [7:0]       r_rx_mem [BUFFER_SIZE];
  logic [AW:0]      r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
  logic             r_rx_overrun, r_frame_err, r_tx_drop;
  logic [1:0]       r_tx_state, r_rx_state;
  logic [CNT_W-1:0] r_tx_cnt, r_rx_cnt;
  logic [2:0]       r_tx_bit, r_rx_bit;
  logic [7:0]       r_tx_shift, r_rx_shift;
  logic             r_tx;
  logic [1:0]       r_rx_sync;

  logic        w_req, w_wr, w_rd;
  logic [1:0]  w_sel;
  logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic        w_tx_cnt_end, w_tx_pop, w_tx_wr, w_tx_push, w_tx_drop;
  logic        w_rx_bit, w_rx_cnt_end, w_rx_stop_pt, w_rx_pop, w_rx_push, w_rx_ovr, w_frm_err;
  logic        w_tx_busy, w_sts_wr;
  logic [7:0]  w_status, w_tx_head, w_rx_head;
  logic [31:0] w_rd_data;
  logic        w_unused;

  assign w_unused = ^{addr_i[31:4], addr_i[1:0], data_i[31:8]};

  // Write has priority over read when both are requested.
  assign w_req = (rd_en_i | wr_en_i) & ~r_ack;
  assign w_wr  = w_req & wr_en_i;
  assign w_rd  = w_req & ~wr_en_i;
  assign w_sel = addr_i[3:2];

  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (r_tx_wptr[AW] != r_tx_rptr[AW]) && (r_tx_wptr[AW-1:0] == r_tx_rptr[AW-1:0]);
  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[AW] != r_rx_rptr[AW]) && (r_rx_wptr[AW-1:0] == r_rx_rptr[AW-1:0]);
  assign w_tx_head  = r_tx_mem[r_tx_rptr[AW-1:0]];
  assign w_rx_head  = r_rx_mem[r_rx_rptr[AW-1:0]];

  assign w_tx_cnt_end = (r_tx_cnt == BAUD_LAST);
  assign w_tx_pop  = ~w_tx_empty & ((r_tx_state == S_IDLE) | ((r_tx_state == S_STOP) & w_tx_cnt_end));
  assign w_tx_wr   = w_wr & (w_sel == 2'd0);
  assign w_tx_push = w_tx_wr & (~w_tx_full | w_tx_pop);
  assign w_tx_drop = w_tx_wr & w_tx_full & ~w_tx_pop;

  // A same-cycle bus pop frees the slot, so a push into a full FIFO is not an overrun.
  assign w_rx_bit     = r_rx_sync[1];
  assign w_rx_cnt_end = (r_rx_cnt == BAUD_LAST);
  assign w_rx_stop_pt = (r_rx_state == S_STOP) & w_rx_cnt_end;
  assign w_rx_pop     = w_rd & (w_sel == 2'd1) & ~w_rx_empty;
  assign w_rx_push    = w_rx_stop_pt & w_rx_bit & (~w_rx_full | w_rx_pop);
  assign w_rx_ovr     = w_rx_stop_pt & w_rx_bit & w_rx_full & ~w_rx_pop;
  assign w_frm_err    = w_rx_stop_pt & ~w_rx_bit;

  assign w_tx_busy = ~w_tx_empty | (r_tx_state != S_IDLE);
  assign w_status  = {w_tx_busy, r_tx_drop, r_frame_err, r_rx_overrun,
                      w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};
  assign w_sts_wr  = w_wr & (w_sel == 2'd2);

`ifdef UART_IRQ_EN
  logic [2:0] r_irq_en;
  logic       r_irq;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_en <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && (w_sel == 2'd3)) r_irq_en <= data_i[2:0];
      r_irq <= |(r_irq_en & {r_rx_overrun | r_frame_err | r_tx_drop, w_tx_empty, ~w_rx_empty});
    end
  end
  assign irq_o = r_irq;
`endif

  always_comb begin
    w_rd_data = '0;
    case (w_sel)
      2'd1: if (!w_rx_empty) w_rd_data = {24'b0, w_rx_head};
      2'd2: w_rd_data = {24'b0, w_status};
`ifdef UART_IRQ_EN
      2'd3: w_rd_data = {29'b0, r_irq_en};
`endif
      default: w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_req;
      r_rdata <= w_rd ? w_rd_data : '0;
    end
  end
  assign ack_o  = r_ack;
  assign data_o = r_rdata;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr[AW-1:0]] <= data_i[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wptr[AW-1:0]] <= r_rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
    end
  end

  // Sticky flags: a new event in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_overrun <= 1'b0;
      r_frame_err  <= 1'b0;
      r_tx_drop    <= 1'b0;
    end else begin
      if (w_sts_wr && data_i[4]) r_rx_overrun <= 1'b0;
      if (w_sts_wr && data_i[5]) r_frame_err  <= 1'b0;
      if (w_sts_wr && data_i[6]) r_tx_drop    <= 1'b0;
      if (w_rx_ovr)  r_rx_overrun <= 1'b1;
      if (w_frm_err) r_frame_err  <= 1'b1;
      if (w_tx_drop) r_tx_drop    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: if (w_tx_pop) begin
          r_tx_shift <= w_tx_head;
          r_tx_state <= S_START;
          r_tx_cnt   <= '0;
          r_tx       <= 1'b0;
        end
        S_START: if (w_tx_cnt_end) begin
          r_tx_cnt   <= '0;
          r_tx_bit   <= '0;
          r_tx_state <= S_DATA;
          r_tx       <= r_tx_shift[0];
        end else r_tx_cnt <= r_tx_cnt + 1'b1;
        S_DATA: if (w_tx_cnt_end) begin
          r_tx_cnt <= '0;
          if (r_tx_bit == 3'd7) begin
            r_tx_state <= S_STOP;
            r_tx       <= 1'b1;
          end else begin
            r_tx_bit   <= r_tx_bit + 1'b1;
            r_tx_shift <= r_tx_shift >> 1;
            r_tx       <= r_tx_shift[1];
          end
        end else r_tx_cnt <= r_tx_cnt + 1'b1;
        S_STOP: if (w_tx_cnt_end) begin
          r_tx_cnt <= '0;
          if (w_tx_pop) begin
            r_tx_shift <= w_tx_head;
            r_tx_state <= S_START;
            r_tx       <= 1'b0;
          end else r_tx_state <= S_IDLE;
        end else r_tx_cnt <= r_tx_cnt + 1'b1;
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end
  assign tx = r_tx;

  // Start bit is confirmed at half a bit, so later samples land mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_sync  <= 2'b11;
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_sync <= {r_rx_sync[0], rx};
      case (r_rx_state)
        S_IDLE: if (!w_rx_bit) begin
          r_rx_state <= S_START;
          r_rx_cnt   <= '0;
        end
        S_START: if (r_rx_cnt == HALF_LAST) begin
          r_rx_cnt   <= '0;
          r_rx_bit   <= '0;
          r_rx_state <= w_rx_bit ? S_IDLE : S_DATA;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        S_DATA: if (w_rx_cnt_end) begin
          r_rx_cnt   <= '0;
          r_rx_shift <= {w_rx_bit, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
          else                  r_rx_bit   <= r_rx_bit + 1'b1;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        S_STOP: if (w_rx_cnt_end) begin
          r_rx_cnt   <= '0;
          r_rx_state <= S_IDLE;
        end else r_rx_cnt <= r_rx_cnt + 1'b1;
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Directed bench for uart_bus_responder at BAUD_DIV=10 with a tx frame monitor.
module tb_uart_bus_responder;
  logic        clk = 1'b0;
  logic        rst, rd_en_i, wr_en_i, rx;
  logic [31:0] addr_i, data_i, data_o;
  logic        ack_o, tx;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ack_cyc = 0;
  int first_ack;
  logic [31:0] rdata;

  logic [7:0] mon_byte[$];
  int         mon_start[$];
  bit         mon_shape[$];

  uart_bus_responder #(.CLOCK_FREQ(1000000), .BIT_RATE(100000), .BUFFER_SIZE(8)) dut (
    .clk(clk), .rst(rst), .rd_en_i(rd_en_i), .wr_en_i(wr_en_i), .addr_i(addr_i),
    .data_i(data_i), .data_o(data_o), .ack_o(ack_o), .rx(rx), .tx(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [99:0] frame_bits(input logic [7:0] b);
    logic [99:0] v;
    int k;
    for (int i = 0; i < 100; i++) begin
      k = i / 10;
      if (k == 0)      v[i] = 1'b0;
      else if (k == 9) v[i] = 1'b1;
      else             v[i] = b[k-1];
    end
    return v;
  endfunction

  // Captures every tx frame as 100 per-cycle samples starting at the start bit.
  initial begin : tx_monitor
    logic [99:0] v;
    logic [7:0]  b;
    int          st;
    forever begin
      @(posedge clk); #2;
      if (rst === 1'b0 && tx === 1'b0) begin
        st = cyc;
        for (int i = 0; i < 100; i++) begin
          v[i] = tx;
          if (i < 99) begin @(posedge clk); #2; end
        end
        for (int j = 0; j < 8; j++) b[j] = v[15 + 10*j];
        mon_byte.push_back(b);
        mon_start.push_back(st);
        mon_shape.push_back(v === frame_bits(b));
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic wr, input logic [1:0] sel, input logic [31:0] wdata,
                     output logic [31:0] rd);
    int n;
    @(negedge clk);
    wr_en_i = wr; rd_en_i = ~wr; addr_i = {28'h0, sel, 2'b00}; data_i = wdata;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (ack_o !== 1'b1 && n < 8);
    check("ack_latency", 32'(n), 32'd1);
    rd = data_o;
    ack_cyc = cyc;
    wr_en_i = 1'b0; rd_en_i = 1'b0;
    $display("[TB] %s reg=%0d wdata=%h rdata=%h", wr ? "wr" : "rd", sel, wdata, rd);
    if (wr) check("wr_ack_data_zero", rd, 32'h0);
    @(posedge clk); #1;
    check("ack_one_cycle", 32'(ack_o), 32'd0);
    check("data_zero_idle", data_o, 32'h0);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] wdata);
    logic [31:0] dummy;
    bus(1'b1, sel, wdata, dummy);
  endtask

  task automatic rd_check(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, sel, 32'h0, r);
    check(tag, r, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rx = f[i];
      repeat (9) @(negedge clk);
    end
    @(negedge clk); rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic mon_clear();
    mon_byte.delete(); mon_start.delete(); mon_shape.delete();
  endtask

  initial begin
    rst = 1'b1; rd_en_i = 1'b0; wr_en_i = 1'b0; addr_i = '0; data_i = '0; rx = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_ack", 32'(ack_o), 32'd0);
    check("reset_data", data_o, 32'h0);
    @(negedge clk); rst = 1'b0;
    rd_check("status_reset", 2'd2, 32'h06);
    rd_check("reserved_read", 2'd3, 32'h0);

    // Single byte: exact waveform and tx falls the cycle after the ack cycle.
    mon_clear();
    wr(2'd0, 32'h55);
    first_ack = ack_cyc;
    repeat (110) @(posedge clk); #1;
    check("tx55_count", 32'(mon_byte.size()), 32'd1);
    check("tx55_byte", 32'(mon_byte[0]), 32'h55);
    check("tx55_shape", 32'(mon_shape[0]), 32'd1);
    check("tx55_latency", 32'(mon_start[0]), 32'(first_ack + 1));
    check("tx55_idle", 32'(tx), 32'd1);
    rd_check("status_tx_done", 2'd2, 32'h06);

    // Nine back-to-back writes from idle: all accepted, no gap between frames.
    mon_clear();
    for (int i = 0; i < 9; i++) begin
      wr(2'd0, 32'h10 + 32'(i));
      if (i == 0) first_ack = ack_cyc;
    end
    repeat (950) @(posedge clk); #1;
    check("burst_count", 32'(mon_byte.size()), 32'd9);
    check("burst_first_latency", 32'(mon_start[0]), 32'(first_ack + 1));
    for (int i = 0; i < 9; i++) begin
      check("burst_byte", 32'(mon_byte[i]), 32'h10 + 32'(i));
      check("burst_shape", 32'(mon_shape[i]), 32'd1);
      if (i > 0) check("burst_gap", 32'(mon_start[i] - mon_start[i-1]), 32'd100);
    end

    // Ten writes while a frame is in flight: the tenth is dropped.
    mon_clear();
    for (int i = 0; i < 10; i++) wr(2'd0, 32'h20 + 32'(i));
    rd_check("status_tx_full_drop", 2'd2, 32'hC5);
    wr(2'd2, 32'h40);
    rd_check("status_drop_cleared", 2'd2, 32'h85);
    repeat (950) @(posedge clk); #1;
    check("drop_count", 32'(mon_byte.size()), 32'd9);
    check("drop_last_byte", 32'(mon_byte[8]), 32'h28);
    rd_check("status_drained", 2'd2, 32'h06);

    // Single receive.
    send_rx(8'hA3, 1'b1);
    rd_check("status_rx_avail", 2'd2, 32'h02);
    rd_check("rx_a3", 2'd1, 32'h000000A3);
    rd_check("rx_empty_read", 2'd1, 32'h0);
    rd_check("status_rx_empty", 2'd2, 32'h06);

    // Nine frames into an 8-deep FIFO.
    for (int i = 0; i < 9; i++) send_rx(8'h61 + 8'(i), 1'b1);
    rd_check("status_rx_overrun", 2'd2, 32'h1A);
    for (int i = 0; i < 8; i++) rd_check("rx_fifo_byte", 2'd1, 32'h61 + 32'(i));
    rd_check("status_after_drain", 2'd2, 32'h16);
    wr(2'd2, 32'h10);
    rd_check("status_ovr_cleared", 2'd2, 32'h06);

    // Bad stop bit, then a short glitch.
    send_rx(8'h77, 1'b0);
    repeat (10) @(negedge clk);
    rd_check("status_frame_err", 2'd2, 32'h26);
    wr(2'd2, 32'h20);
    rd_check("status_ferr_cleared", 2'd2, 32'h06);
    @(negedge clk); rx = 1'b0;
    repeat (3) @(negedge clk); rx = 1'b1;
    repeat (30) @(negedge clk);
    rd_check("status_after_glitch", 2'd2, 32'h06);

    // Reset in the middle of a tx frame (byte 0x00 keeps tx low) and an rx frame.
    wr(2'd0, 32'h00);
    wr(2'd0, 32'hC4);
    wr(2'd0, 32'hC5);
    @(negedge clk); rx = 1'b0;
    repeat (25) @(negedge clk);
    rst = 1'b1; rx = 1'b1;
    @(posedge clk); #1;
    check("tx_after_rst", 32'(tx), 32'd1);
    check("ack_after_rst", 32'(ack_o), 32'd0);
    @(negedge clk); rst = 1'b0;
    rd_check("status_after_rst", 2'd2, 32'h06);
    repeat (120) @(posedge clk); #1;
    mon_clear();
    wr(2'd0, 32'h3C);
    first_ack = ack_cyc;
    repeat (110) @(posedge clk); #1;
    check("post_rst_count", 32'(mon_byte.size()), 32'd1);
    check("post_rst_byte", 32'(mon_byte[0]), 32'h3C);
    check("post_rst_shape", 32'(mon_shape[0]), 32'd1);
    check("post_rst_latency", 32'(mon_start[0]), 32'(first_ack + 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_bus_responder.md
Name: uart_bus_responder

Overview:
- Memory-mapped UART on the SoC's simple rd_en/wr_en/addr/data/ack bus: the responder end that the core drives, selected by the SoC address decoder.
- Serialises bytes written by the core onto tx.
- Deserialises rx into a receive FIFO that the core reads.
- Format is fixed 8N1, LSB first; both directions are buffered by FIFOs.

Parameters:
- CLOCK_FREQ, 25000000, clk frequency in Hz.
- BIT_RATE, 9600, baud rate. Bit period BAUD_DIV = CLOCK_FREQ/BIT_RATE, integer division truncated; must be >= 4.
- BUFFER_SIZE, 8, depth of each of the TX and RX FIFOs; power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rd_en_i  input  1  bus read request.
- wr_en_i  input  1  bus write request.
- addr_i  input  32  byte address; only addr_i[3:2] is decoded.
- data_i  input  32  write data; only data_i[7:0] is used.
- data_o  output  32  read data; valid in the ack cycle.
- ack_o  output  1  one-cycle transfer acknowledge.
- rx  input  1  serial input, asynchronous; idle high.
- tx  output  1  serial output; idle high.

Behaviour:
- Reset values: tx=1, ack_o=0, data_o=0. Both FIFOs empty, all sticky flags 0, TX and RX FSMs in IDLE.
- rst asserted mid-frame aborts that frame immediately; tx returns high on the next edge.
- Bus handshake:
  - A request is accepted on any edge where (rd_en_i|wr_en_i)=1 and ack_o=0.
  - ack_o goes high on the next edge for exactly one cycle.
  - Requests present while ack_o=1 are ignored. The initiator holds request signals until ack and drops them in the ack cycle.
  - If rd_en_i and wr_en_i are both high, the write wins.
  - data_o=0 outside the ack cycle and for write acks.
- Register map (addr_i[3:2]):
  - 0 TXDATA: write pushes data_i[7:0] into the TX FIFO. If the FIFO is full the byte is dropped and tx_drop is set. Reads return 0.
  - 1 RXDATA: read returns {24'b0, head byte} and pops it. If the FIFO is empty, returns 0 and does not pop. Writes are ignored.
  - 2 STATUS (read): bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full, bit4 rx_overrun, bit5 frame_err, bit6 tx_drop, bit7 tx_busy (FIFO non-empty or frame in progress).
  - 2 STATUS (write): writing 1 to bits 4..6 clears those sticky flags; all other bits are ignored.
  - 3 reserved: reads 0, writes ignored (IRQ_EN when the optional feature is built).
- FIFOs: log2(BUFFER_SIZE)+1-bit read/write pointers with natural wrap. A push and a pop in the same cycle on the same FIFO are both performed; this is legal even when the FIFO is full or empty, as the side condition permits.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: when the FIFO is non-empty, pop one byte and enter START.
  - Each of START, DATA and STOP lasts BAUD_DIV cycles. START drives tx=0; DATA drives bits 0..7 in order; STOP drives tx=1.
  - After STOP, the FSM goes directly to START if the FIFO is non-empty, so back-to-back frames have no idle gap; otherwise it goes to IDLE.
  - Latency: a write acked at cycle N produces tx falling at cycle N+1 or N+2 when the FSM was idle.
- RX FSM (IDLE, START, DATA, STOP):
  - rx passes through a 2-flop synchronizer.
  - IDLE: a synchronized low level enters START.
  - START: the bit is checked at BAUD_DIV/2. If it is high, the event is treated as a glitch and the FSM returns to IDLE.
  - DATA: 8 bits are sampled every BAUD_DIV cycles, each at mid-bit.
  - STOP: if the stop bit is 1, the byte is pushed to the FIFO; if the FIFO is full, the byte is discarded and rx_overrun is set.
  - If the stop bit is 0, the byte is discarded and frame_err is set.
  - The FSM returns to IDLE at the stop-bit sample point.
- A bus read that pops RXDATA in the same cycle the RX FSM pushes into a full FIFO is not an overrun.

Optional Feature:
- Macro UART_IRQ_EN.
- When defined:
  - Adds output irq_o, 1 bit, reset 0.
  - Offset 3 becomes IRQ_EN (read/write bits [2:0], reset 0): bit0 rx-not-empty, bit1 tx-empty, bit2 any sticky error.
  - irq_o is registered as the OR of each enabled bit ANDed with its condition, and updates one cycle after the condition.
- When undefined: no irq_o port, and offset 3 behaves as reserved.

Test Plan:
- Reset with CLOCK_FREQ=1000000, BIT_RATE=100000 (BAUD_DIV=10) -> tx=1, ack_o=0; STATUS read returns 0x06.
- Write 0x55 to TXDATA -> ack_o one cycle later; tx shows start bit, then 1,0,1,0,1,0,1,0, then stop, each bit exactly 10 cycles; STATUS bit7 returns to 0 after the stop bit.
- Write 9 bytes back-to-back with tx idle and BUFFER_SIZE=8 -> first byte popped on the first cycle, so all 9 accepted and sent with no idle gap. Repeat while a frame is in progress so 10 writes arrive with the FIFO full -> 10th dropped, tx_drop=1; writing STATUS=0x40 clears it.
- Drive rx frame 0xA3 at 10 cycles/bit -> STATUS bit2=0; RXDATA read returns 0x000000A3; a second RXDATA read returns 0 and STATUS bit2=1.
- Drive 9 rx frames without reading -> rx_full=1, rx_overrun=1, and the first 8 bytes are read back intact. A frame with stop bit 0 -> frame_err=1 and no push. A 3-cycle low glitch on rx -> no push and no flag.
- Assert rst mid-TX frame and mid-RX frame, then deassert -> tx=1 next cycle, FIFOs empty, flags clear; the next write transmits correctly.
